crc3_dma: RTL and testbench
===========================

Name: crc3_dma

Overview:
- Memory-scanning CRC-32 accelerator.
- Host programs it through a 32-bit Avalon-MM slave (ctrl_*).
- It fetches a block of 64-bit words from system memory through an Avalon-MM read master (master_*) and folds each word into a CRC-32 register.
- On completion it exposes the result and optionally raises irq.

Parameters:
- ADDR_W, 3, ctrl_address width (word-indexed register map).
- POLY, 32'h04C11DB7, CRC-32 generator polynomial (MSB-first, non-reflected).
- SEED_DEFAULT, 32'hFFFFFFFF, reset value of SEED register.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- ctrl_write  in  1  slave write strobe.
- ctrl_writedata  in  32  slave write data.
- ctrl_read  in  1  slave read strobe.
- ctrl_address  in  ADDR_W  register index (upper bits of a wider driver ignored).
- ctrl_readdata  out  32  slave read data.
- ctrl_waitrequest  out  1  slave stall.
- master_read  out  1  master read request.
- master_address  out  32  byte address, 8-byte aligned.
- master_readdata  in  64  returned word.
- master_waitrequest  in  1  fabric stall.
- master_readdatavalid  in  1  master_readdata valid.
- master_burstcount  out  1  constant 1.
- master_byteenable  out  8  constant 8'hFF.
- irq  out  1  level interrupt.

Behaviour:
Reset:
- All outputs 0 except master_byteenable=8'hFF and master_burstcount=1.
- ADDR=0, LEN=0, SEED=SEED_DEFAULT, RESULT=0, busy=0, done=0, irq_en=0.
- Reset mid-transfer aborts at once: master_read drops the next cycle, no result latch. A late readdatavalid after reset is ignored.

Register map (ctrl_address):
- 0 CTRL
  - Write: bit0=START (self-clearing pulse), bit1=IRQ_EN.
  - Read: bit0=busy, bit1=irq_en, bit2=done.
- 1 ADDR: start byte address, R/W. Bits[2:0] are forced to 0.
- 2 LEN: number of 64-bit words, R/W.
- 3 SEED: initial CRC value, R/W.
- 4 RESULT: final CRC, read-only. Writes ignored.
- 5 IRQCLR: write bit0=1 clears done. Reads as 0.
- 6-7: read 0, writes ignored.

Slave timing:
- Writes complete in one cycle; ctrl_waitrequest stays 0 for writes.
- Reads are registered: ctrl_waitrequest=1 in the first cycle of ctrl_read, 0 in the second, with ctrl_readdata valid in that second cycle.
- Simultaneous ctrl_read and ctrl_write: write takes effect, read proceeds normally.

Write protection while busy:
- Writes to ADDR/LEN/SEED and START are ignored.
- IRQ_EN and IRQCLR writes are honoured.

State machine IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE:
- IDLE
  - On START with LEN!=0: crc<=SEED, ptr<=ADDR, remaining<=LEN, busy=1, clear done, go REQ.
  - On START with LEN==0: RESULT<=SEED, done=1, remain IDLE.
- REQ
  - master_read=1, master_address=ptr, both held stable while master_waitrequest=1.
  - On accept (master_read & ~master_waitrequest): drop master_read next cycle, ptr+=8, go WAIT.
- WAIT
  - On master_readdatavalid: crc<=f(crc, master_readdata), remaining-=1.
  - If remaining becomes 0, go DONE, else go REQ.
- DONE (1 cycle): RESULT<=crc, busy=0, done=1, go IDLE.
- One read outstanding at most. readdatavalid outside WAIT is ignored.

CRC update f:
- Process master_readdata as 8 bytes, byte 0 (bits 7:0) first through byte 7.
- Each byte is processed MSB first.
- Standard shift-left CRC with POLY; no final XOR; no reflection.
- All 64 bits are folded in one clock (combinational unroll).

Other rules:
- ptr wraps modulo 2^32 with no error.
- irq = done & irq_en, registered; irq rises the cycle after done sets.
- irq drops the cycle after done clears or irq_en clears.
- A new START clears done.

Test Plan:
- Reset: assert reset 1 cycle mid-idle -> irq=0, master_read=0, reading SEED returns 32'hFFFFFFFF, CTRL returns 0.
- Zero-length: LEN=0, SEED=32'h12345678, CTRL=3 -> no master_read, RESULT=32'h12345678, CTRL reads 6, irq=1 after one cycle; IRQCLR=1 -> irq=0.
- Zero data: ADDR=32'h1000, LEN=4, SEED=0, memory returns all zero, START -> master_address sequence 1000,1008,1010,1018; RESULT=0; done set.
- Waitrequest/latency: LEN=2, master_waitrequest held 3 cycles per request, readdatavalid 5 cycles after accept -> master_read/address stable during stall, exactly 2 requests, RESULT matches software model (SEED FFFFFFFF, MPEG-2 bitwise).
- Busy protection: during transfer write LEN=99 and START -> ignored, LEN reads original value, single completion.
- Reset mid-transfer: reset while in WAIT, then readdatavalid pulse -> busy=0, RESULT unchanged (0), no irq.

Source files
------------

// File: rtl/crc3_dma.sv
// rtl/crc3_dma.sv - memory-scanning CRC-32 accelerator with Avalon-MM slave and read master
module crc3_dma #(
    parameter int          ADDR_W       = 3,
    parameter logic [31:0] POLY         = 32'h04C11DB7,
    parameter logic [31:0] SEED_DEFAULT = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_write,
    input  logic [31:0]       ctrl_writedata,
    input  logic              ctrl_read,
    input  logic [ADDR_W-1:0] ctrl_address,
    output logic [31:0]       ctrl_readdata,
    output logic              ctrl_waitrequest,
    output logic              master_read,
    output logic [31:0]       master_address,
    input  logic [63:0]       master_readdata,
    input  logic              master_waitrequest,
    input  logic              master_readdatavalid,
    output logic              master_burstcount,
    output logic [7:0]        master_byteenable,
    output logic              irq
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_r, len_r, seed_r, result_r;
    logic [31:0] crc_r, ptr_r, remain_r;
    logic        done_r, irq_en_r, rd_phase;
    logic [2:0]  reg_idx;
    logic        idle, start;
    logic [31:0] rd_mux;

    // Byte 0 first, each byte MSB first, all 64 bits unrolled into one cycle.
    function automatic logic [31:0] crc_fold(input logic [31:0] c_in, input logic [63:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[31] ^ d[8*b+i];
                c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'd0);
            end
        end
        return c;
    endfunction

    assign reg_idx           = ctrl_address[2:0];
    assign idle              = (state == S_IDLE);
    assign start             = ctrl_write && (reg_idx == 3'd0) && ctrl_writedata[0] && idle;
    assign master_read       = (state == S_REQ);
    assign master_address    = ptr_r;
    assign master_burstcount = 1'b1;
    assign master_byteenable = 8'hFF;
    assign ctrl_waitrequest  = ctrl_read && !rd_phase;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && len_r != 32'd0) state_nxt = S_REQ;
            S_REQ:  if (!master_waitrequest) state_nxt = S_WAIT;
            S_WAIT: if (master_readdatavalid) state_nxt = (remain_r == 32'd1) ? S_DONE : S_REQ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (reg_idx)
            3'd0: rd_mux = {29'd0, done_r, irq_en_r, !idle};
            3'd1: rd_mux = addr_r;
            3'd2: rd_mux = len_r;
            3'd3: rd_mux = seed_r;
            3'd4: rd_mux = result_r;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r        <= 32'd0;
            len_r         <= 32'd0;
            seed_r        <= SEED_DEFAULT;
            result_r      <= 32'd0;
            crc_r         <= 32'd0;
            ptr_r         <= 32'd0;
            remain_r      <= 32'd0;
            done_r        <= 1'b0;
            irq_en_r      <= 1'b0;
            irq           <= 1'b0;
            rd_phase      <= 1'b0;
            ctrl_readdata <= 32'd0;
        end else begin
            if (ctrl_write) begin
                case (reg_idx)
                    3'd0: irq_en_r <= ctrl_writedata[1];
                    3'd1: if (idle) addr_r <= {ctrl_writedata[31:3], 3'b000};
                    3'd2: if (idle) len_r  <= ctrl_writedata;
                    3'd3: if (idle) seed_r <= ctrl_writedata;
                    3'd5: if (ctrl_writedata[0]) done_r <= 1'b0;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_r != 32'd0) begin
                            crc_r    <= seed_r;
                            ptr_r    <= addr_r;
                            remain_r <= len_r;
                            done_r   <= 1'b0;
                        end else begin
                            result_r <= seed_r;
                            done_r   <= 1'b1;
                        end
                    end
                end
                S_REQ: if (!master_waitrequest) ptr_r <= ptr_r + 32'd8;
                S_WAIT: begin
                    if (master_readdatavalid) begin
                        crc_r    <= crc_fold(crc_r, master_readdata);
                        remain_r <= remain_r - 32'd1;
                    end
                end
                S_DONE: begin
                    result_r <= crc_r;
                    done_r   <= 1'b1;
                end
                default: ;
            endcase

            irq <= done_r && irq_en_r;

            // Data is captured in the stall cycle and presented in the second.
            rd_phase <= ctrl_read && !rd_phase;
            if (ctrl_read && !rd_phase) ctrl_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_crc3_dma.sv
// tb/tb_crc3_dma.sv - self-checking bench for crc3_dma with memory fabric model
module tb_crc3_dma;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_write = 1'b0;
    logic [31:0] ctrl_writedata = 32'd0;
    logic        ctrl_read = 1'b0;
    logic [2:0]  ctrl_address = 3'd0;
    logic [31:0] ctrl_readdata;
    logic        ctrl_waitrequest;
    logic        master_read;
    logic [31:0] master_address;
    logic [63:0] master_readdata = 64'd0;
    logic        master_waitrequest = 1'b0;
    logic        master_readdatavalid = 1'b0;
    logic        master_burstcount;
    logic [7:0]  master_byteenable;
    logic        irq;

    crc3_dma dut (
        .clk(clk), .reset(reset),
        .ctrl_write(ctrl_write), .ctrl_writedata(ctrl_writedata),
        .ctrl_read(ctrl_read), .ctrl_address(ctrl_address),
        .ctrl_readdata(ctrl_readdata), .ctrl_waitrequest(ctrl_waitrequest),
        .master_read(master_read), .master_address(master_address),
        .master_readdata(master_readdata), .master_waitrequest(master_waitrequest),
        .master_readdatavalid(master_readdatavalid), .master_burstcount(master_burstcount),
        .master_byteenable(master_byteenable), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem [logic [31:0]];
    logic [31:0] acc_q[$];
    int          cfg_stall = 0;
    int          cfg_lat   = 1;
    bit          fab_en    = 1'b1;
    int          stall_err = 0;
    logic        wr_first, wr_second;

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    // Bytewise MPEG-2 CRC over the little-endian byte stream of the block.
    function automatic logic [31:0] crc_model(input logic [31:0] seed, input logic [31:0] a, input int len);
        logic [31:0] c;
        logic [63:0] d;
        c = seed;
        for (int w = 0; w < len; w++) begin
            d = mem_rd(a + 32'(8 * w));
            for (int b = 0; b < 8; b++) begin
                c = c ^ {d[8*b +: 8], 24'd0};
                for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
            end
        end
        return c;
    endfunction

    // Fabric: stalls each request cfg_stall cycles, answers cfg_lat cycles after accept.
    initial begin
        int          vcnt, stall_left;
        bit          prev_stalled;
        logic [31:0] prev_addr, pend_addr;
        vcnt = 0; stall_left = 0; prev_stalled = 0; prev_addr = 0; pend_addr = 0;
        forever begin
            @(negedge clk);
            if (!fab_en) begin
                vcnt = 0; stall_left = cfg_stall; prev_stalled = 0;
            end else begin
                master_readdatavalid = 1'b0;
                if (vcnt > 0) begin
                    vcnt--;
                    if (vcnt == 0) begin
                        master_readdatavalid = 1'b1;
                        master_readdata = mem_rd(pend_addr);
                    end
                end
                if (prev_stalled && (!master_read || master_address != prev_addr)) stall_err++;
                if (master_read) begin
                    if (stall_left > 0) begin
                        master_waitrequest = 1'b1; stall_left--;
                        prev_stalled = 1; prev_addr = master_address;
                    end else begin
                        master_waitrequest = 1'b0; prev_stalled = 0;
                        acc_q.push_back(master_address);
                        pend_addr = master_address; vcnt = cfg_lat;
                    end
                end else begin
                    master_waitrequest = 1'b0; stall_left = cfg_stall; prev_stalled = 0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic ctrl_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        ctrl_write = 1'b1; ctrl_address = a; ctrl_writedata = d;
        @(negedge clk);
        ctrl_write = 1'b0;
    endtask

    task automatic ctrl_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        ctrl_read = 1'b1; ctrl_address = a;
        #1 wr_first = ctrl_waitrequest;
        @(negedge clk);
        wr_second = ctrl_waitrequest;
        d = ctrl_readdata;
        ctrl_read = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        logic [31:0] v;
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            ctrl_rd(3'd0, v);
            if (v[0] == 1'b0 && v[2] == 1'b1) ok = 1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got busy/not-done expected done within budget", nm);
        end
    endtask

    task automatic run_xfer(input string nm, input logic [31:0] a, input int len,
                            input logic [31:0] seed, input bit ien, input bit zero);
        logic [31:0] v, exp;
        int n;
        mem.delete();
        for (int i = 0; i < len; i++) mem[a + 32'(8 * i)] = zero ? 64'd0 : {$urandom, $urandom};
        acc_q.delete();
        ctrl_wr(3'd1, a);
        ctrl_wr(3'd2, 32'(len));
        ctrl_wr(3'd3, seed);
        ctrl_wr(3'd0, {30'd0, ien, 1'b1});
        wait_done(nm);
        check($sformatf("%s_nreq", nm), 32'(acc_q.size()), 32'(len));
        n = (acc_q.size() < len) ? acc_q.size() : len;
        for (int i = 0; i < n; i++)
            check($sformatf("%s_addr%0d", nm, i), acc_q[i], a + 32'(8 * i));
        exp = crc_model(seed, a, len);
        ctrl_rd(3'd4, v);
        check($sformatf("%s_result", nm), v, exp);
        ctrl_rd(3'd0, v);
        check($sformatf("%s_ctrl", nm), v, {29'd0, 1'b1, ien, 1'b0});
        check($sformatf("%s_irq", nm), {31'd0, irq}, {31'd0, ien});
        ctrl_wr(3'd5, 32'd1);
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp;
    } wr_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t     rst_tab[8];
        wr_vec_t     wr_tab[9];
        logic [31:0] v;
        int          wcnt;

        rst_tab[0] = '{3'd0, 32'h0};
        rst_tab[1] = '{3'd1, 32'h0};
        rst_tab[2] = '{3'd2, 32'h0};
        rst_tab[3] = '{3'd3, 32'hFFFFFFFF};
        rst_tab[4] = '{3'd4, 32'h0};
        rst_tab[5] = '{3'd5, 32'h0};
        rst_tab[6] = '{3'd6, 32'h0};
        rst_tab[7] = '{3'd7, 32'h0};

        wr_tab[0] = '{3'd1, 32'h1234567F, 3'd1, 32'h12345678};
        wr_tab[1] = '{3'd2, 32'h00000007, 3'd2, 32'h00000007};
        wr_tab[2] = '{3'd3, 32'hDEADBEEF, 3'd3, 32'hDEADBEEF};
        wr_tab[3] = '{3'd4, 32'hFFFFFFFF, 3'd4, 32'h00000000};
        wr_tab[4] = '{3'd6, 32'hFFFFFFFF, 3'd6, 32'h00000000};
        wr_tab[5] = '{3'd7, 32'h00000001, 3'd7, 32'h00000000};
        wr_tab[6] = '{3'd5, 32'h00000001, 3'd5, 32'h00000000};
        wr_tab[7] = '{3'd0, 32'h00000002, 3'd0, 32'h00000002};
        wr_tab[8] = '{3'd0, 32'h00000000, 3'd0, 32'h00000000};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset mid-idle restores defaults
        ctrl_wr(3'd3, 32'h00001234);
        ctrl_wr(3'd0, 32'h00000002);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_mread", {31'd0, master_read}, 32'd0);
        check("rst_be", {24'd0, master_byteenable}, 32'h000000FF);
        check("rst_burst", {31'd0, master_burstcount}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            ctrl_rd(rst_tab[i].addr, v);
            check($sformatf("rst_reg%0d", rst_tab[i].addr), v, rst_tab[i].exp);
        end
        check("rd_wait_first", {31'd0, wr_first}, 32'd1);
        check("rd_wait_second", {31'd0, wr_second}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            ctrl_wr(wr_tab[i].waddr, wr_tab[i].wdata);
            ctrl_rd(wr_tab[i].raddr, v);
            check($sformatf("wr_vec%0d", i), v, wr_tab[i].exp);
        end

        // Zero-length transfer
        acc_q.delete();
        ctrl_wr(3'd2, 32'd0);
        ctrl_wr(3'd3, 32'h12345678);
        ctrl_wr(3'd0, 32'd3);
        check("zl_irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("zl_irq", {31'd0, irq}, 32'd1);
        ctrl_rd(3'd4, v);
        check("zl_result", v, 32'h12345678);
        ctrl_rd(3'd0, v);
        check("zl_ctrl", v, 32'd6);
        check("zl_noreq", 32'(acc_q.size()), 32'd0);
        ctrl_wr(3'd5, 32'd1);
        @(negedge clk);
        check("zl_irqclr", {31'd0, irq}, 32'd0);
        ctrl_wr(3'd0, 32'd0);

        // Zero data, four words
        cfg_stall = 0; cfg_lat = 1;
        run_xfer("zero", 32'h00001000, 4, 32'h0, 1'b0, 1'b1);

        // Waitrequest and latency
        cfg_stall = 3; cfg_lat = 5;
        run_xfer("stall", 32'h00004000, 2, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("stall_stable", 32'(stall_err), 32'd0);

        // Busy protection
        cfg_stall = 2; cfg_lat = 3;
        mem.delete();
        for (int i = 0; i < 6; i++) mem[32'h00008000 + 32'(8 * i)] = {$urandom, $urandom};
        acc_q.delete();
        ctrl_wr(3'd1, 32'h00008000);
        ctrl_wr(3'd2, 32'd6);
        ctrl_wr(3'd3, 32'hFFFFFFFF);
        ctrl_wr(3'd0, 32'd1);
        ctrl_wr(3'd2, 32'd99);
        ctrl_wr(3'd1, 32'h00000100);
        ctrl_wr(3'd0, 32'd1);
        ctrl_rd(3'd2, v);
        check("busy_len", v, 32'd6);
        ctrl_rd(3'd1, v);
        check("busy_addr", v, 32'h00008000);
        wait_done("busy");
        repeat (40) @(negedge clk);
        check("busy_nreq", 32'(acc_q.size()), 32'd6);
        ctrl_rd(3'd0, v);
        check("busy_ctrl", v, 32'd4);
        ctrl_rd(3'd4, v);
        check("busy_result", v, crc_model(32'hFFFFFFFF, 32'h00008000, 6));
        ctrl_wr(3'd5, 32'd1);

        // Randomized transfers, first one wraps the address space
        for (int t = 0; t < 8; t++) begin
            cfg_stall = $urandom_range(0, 3);
            cfg_lat   = $urandom_range(1, 4);
            run_xfer($sformatf("rnd%0d", t),
                     (t == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFF8),
                     $urandom_range(1, 5), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("rnd_stable", 32'(stall_err), 32'd0);

        // Reset mid-transfer: mode 0 in REQ under stall, mode 1 in WAIT
        for (int m = 0; m < 2; m++) begin
            fab_en = 1'b1;
            cfg_stall = (m == 0) ? 20 : 0;
            cfg_lat   = (m == 0) ? 1 : 40;
            acc_q.delete();
            ctrl_wr(3'd1, 32'h00002000);
            ctrl_wr(3'd2, 32'd3);
            ctrl_wr(3'd3, 32'h0);
            ctrl_wr(3'd0, 32'd3);
            if (m == 0) begin
                repeat (3) @(negedge clk);
                check("mrst_req_active", {31'd0, master_read}, 32'd1);
            end else begin
                wcnt = 0;
                while (acc_q.size() == 0 && wcnt < 50) begin @(negedge clk); wcnt++; end
                check("mrst_wait_reached", 32'(acc_q.size()), 32'd1);
                repeat (2) @(negedge clk);
            end
            @(negedge clk);
            reset = 1'b1; fab_en = 1'b0;
            master_waitrequest = 1'b0; master_readdatavalid = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            check($sformatf("mrst%0d_mread", m), {31'd0, master_read}, 32'd0);
            master_readdatavalid = 1'b1;
            master_readdata = {$urandom, $urandom};
            @(negedge clk);
            master_readdatavalid = 1'b0;
            repeat (3) @(negedge clk);
            ctrl_rd(3'd0, v);
            check($sformatf("mrst%0d_ctrl", m), v, 32'd0);
            ctrl_rd(3'd4, v);
            check($sformatf("mrst%0d_result", m), v, 32'd0);
            check($sformatf("mrst%0d_irq", m), {31'd0, irq}, 32'd0);
            check($sformatf("mrst%0d_mread_idle", m), {31'd0, master_read}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
